dcache_controller: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache and controller between the single-cycle RISC-V datapath and word-wide main memory.

---
 rtl/dcache_controller.sv | 181 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache between the datapath and word-wide memory.
// Latency: read hits return rdata in the same cycle. A read miss costs the sum of the per-word memory latencies plus 1 cycle.
// Backpressure: stall holds the datapath through each miss or store. The memory request is held until the mem_ready strobe.
module dcache_controller #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 3,
   parameter int OFFSET_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int LINES = 2**INDEX_W;
   localparam int WORDS = 2**OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

   state_t               state;
   logic [LINES-1:0]     valid;
   logic [TAG_W-1:0]     tag_q   [LINES];
   logic [31:0]          data_q  [LINES*WORDS];
   logic [TAG_W-1:0]     tag_l;
   logic [INDEX_W-1:0]   index_l;
   logic [OFFSET_W-1:0]  cnt;
   logic [OFFSET_W-1:0]  cnt_nxt;
   logic [ADDR_W-3:0]    waddr_l;
   logic [31:0]          wdata_l;
   logic                 refill_flag;

   logic [TAG_W-1:0]     tag_in;
   logic [INDEX_W-1:0]   index_in;
   logic [OFFSET_W-1:0]  word_in;
   logic                 hit;
   logic [TAG_W-1:0]     w_tag;
   logic [INDEX_W-1:0]   w_index;
   logic [OFFSET_W-1:0]  w_word;
   logic                 w_hit;
   logic                         data_we;
   logic [INDEX_W+OFFSET_W-1:0]  data_sel;
   logic [31:0]                  data_val;
   logic                 unused_addr_bits;

   assign tag_in   = addr[ADDR_W-1 -: TAG_W];
   assign index_in = addr[OFFSET_W+2 +: INDEX_W];
   assign word_in  = addr[2 +: OFFSET_W];
   assign hit      = valid[index_in] && (tag_q[index_in] == tag_in);
   assign unused_addr_bits = ^addr[1:0];

   // Store lookup uses the address latched when the store was accepted
   assign w_tag   = waddr_l[ADDR_W-3 -: TAG_W];
   assign w_index = waddr_l[OFFSET_W +: INDEX_W];
   assign w_word  = waddr_l[OFFSET_W-1:0];
   assign w_hit   = valid[w_index] && (tag_q[w_index] == w_tag);
   assign cnt_nxt = cnt + OFFSET_W'(1);

   // Single data-array write port: refill words, or store data on a write hit
   always_comb begin
      data_we  = 1'b0;
      data_sel = {index_l, cnt};
      data_val = mem_rdata;
      if (state == REFILL && mem_ready) begin
         data_we = 1'b1;
      end else if (state == WRITE && mem_ready && w_hit) begin
         data_we  = 1'b1;
         data_sel = {w_index, w_word};
         data_val = wdata_l;
      end
   end

   // Data array carries no reset; valid[] guards every read of it
   always_ff @(posedge clk) begin
      if (data_we) data_q[data_sel] <= data_val;
   end

   // Datapath-facing outputs: stall is raised in the same cycle a miss or store is seen
   always_comb begin
      stall = 1'b0;
      rdata = '0;
      case (state)
         IDLE: begin
            if (mem_write) begin
               stall = 1'b1;
            end else if (mem_read) begin
               if (hit) rdata = data_q[{index_in, word_in}];
               else     stall = 1'b1;
            end
         end
         REFILL, WRITE: stall = 1'b1;
         default: ;
      endcase
   end

   // Controller FSM with registered memory-side outputs and statistics counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         valid       <= '0;
         for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
         tag_l       <= '0;
         index_l     <= '0;
         cnt         <= '0;
         waddr_l     <= '0;
         wdata_l     <= '0;
         refill_flag <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_write) begin
                  waddr_l   <= addr[ADDR_W-1:2];
                  wdata_l   <= wdata;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= wdata;
                  state     <= WRITE;
               end else if (mem_read) begin
                  if (hit) begin
                     // The retried access that ends a refill is not counted as a hit
                     if (!refill_flag && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                     refill_flag <= 1'b0;
                  end else begin
                     // Invalidate first so a half-filled line can never look valid
                     valid[index_in] <= 1'b0;
                     tag_l    <= tag_in;
                     index_l  <= index_in;
                     cnt      <= '0;
                     if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= {tag_in, index_in, {OFFSET_W{1'b0}}, 2'b00};
                     state    <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  cnt      <= cnt_nxt;
                  mem_addr <= {tag_l, index_l, cnt_nxt, 2'b00};
                  if (cnt == LAST_WORD) begin
                     valid[index_l] <= 1'b1;
                     tag_q[index_l] <= tag_l;
                     refill_flag    <= 1'b1;
                     mem_req        <= 1'b0;
                     state          <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= WDONE;
               end
            end
            WDONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a word memory with per-request latency and a high-level cache model.
// The model tracks line valid and tag, and hit/miss counts. Expected load data is always the memory contents.
// The bench drives inputs on the falling edge and samples outputs 1 time unit later.
module tb_dcache_controller;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write;
   logic [9:0]  addr;
   logic [31:0] wdata, rdata;
   logic        stall, mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [15:0] hit_cnt, miss_cnt;

   dcache_controller dut (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat_cfg  = 3;   // 0 selects a random latency per request
   int          lat_sum  = 0;
   logic [31:0] mem [256];
   logic [9:0]  rd_q [$];
   logic [41:0] wr_q [$];

   // Reference model state
   bit          m_valid [8];
   logic [2:0]  m_tag   [8];
   int          m_hit = 0, m_miss = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory responder: mem_ready is raised in the L-th cycle that a request is presented
   initial begin : responder
      int         age;
      int         cur_lat;
      logic [9:0] req_addr;
      logic       req_we;
      logic [31:0] req_wd;
      age = 0; cur_lat = 1; req_addr = '0; req_we = 1'b0; req_wd = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            age = 0;
         end
         if (!mem_req) begin
            age = 0;
         end else begin
            if (age == 0) begin
               cur_lat  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
               lat_sum += cur_lat;
               req_addr = mem_addr;
               req_we   = mem_we;
               req_wd   = mem_wdata;
               if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
               else        rd_q.push_back(mem_addr);
            end else begin
               check("hs_stable", {mem_we, mem_addr, req_we ? mem_wdata : 32'd0},
                                  {req_we, req_addr, req_we ? req_wd : 32'd0});
            end
            age++;
            if (age == cur_lat) begin
               mem_ready = 1'b1;
               if (req_we) mem[req_addr[9:2]] = req_wd;
               else        mem_rdata = mem[req_addr[9:2]];
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_hit = 0;
      m_miss = 0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_stall"}, stall, 1'b0);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_hit_cnt"}, hit_cnt, 16'(m_hit));
      check({tag, "_miss_cnt"}, miss_cnt, 16'(m_miss));
   endtask

   task automatic do_load(input logic [9:0] a);
      logic [2:0] ti, ii;
      bit         exp_miss;
      int         ncyc;
      logic [9:0] ea;
      ti = a[9:7];
      ii = a[6:4];
      exp_miss = !(m_valid[ii] && m_tag[ii] == ti);
      @(negedge clk);
      mem_write = 1'b0; mem_read = 1'b1; addr = a; wdata = $urandom;
      rd_q.delete();
      lat_sum = 0;
      #1;
      ncyc = 0;
      while (stall === 1'b1 && ncyc < 200) begin
         ncyc++;
         @(negedge clk); #1;
      end
      check("ld_stall_cycles", ncyc, exp_miss ? 1 + lat_sum : 0);
      check("ld_rdata", rdata, mem[a[9:2]]);
      check("ld_no_req", mem_req, 1'b0);
      if (exp_miss) begin
         check("ld_refill_words", rd_q.size(), 4);
         for (int k = 0; k < rd_q.size(); k++) begin
            ea = {a[9:4], 4'b0000} + 10'(k * 4);
            check("ld_refill_addr", rd_q[k], ea);
         end
         m_miss++;
         m_valid[ii] = 1'b1;
         m_tag[ii] = ti;
      end else begin
         check("ld_no_refill", rd_q.size(), 0);
         m_hit++;
      end
      @(negedge clk);
      mem_read = 1'b0;
      #1;
      check_idle("ld_after");
   endtask

   task automatic do_store(input logic [9:0] a, input logic [31:0] d, input logic both);
      int ncyc;
      @(negedge clk);
      mem_write = 1'b1; mem_read = both; addr = a; wdata = d;
      wr_q.delete();
      lat_sum = 0;
      #1;
      check("st_stall_first", stall, 1'b1);
      ncyc = 0;
      while (stall === 1'b1 && ncyc < 200) begin
         ncyc++;
         @(negedge clk); #1;
      end
      check("st_stall_cycles", ncyc, 1 + lat_sum);
      check("st_wdone_req", mem_req, 1'b0);
      check("st_writes", wr_q.size(), 1);
      if (wr_q.size() > 0) check("st_addr_data", wr_q[0], {a[9:2], 2'b00, d});
      @(negedge clk);
      mem_write = 1'b0; mem_read = 1'b0;
      #1;
      check_idle("st_after");
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [9:0] ra;
      reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int k = 0; k < 4; k++) mem[4 + k] = 32'hA0 + 32'(k);
      model_reset();
      #12;
      check("rst_outputs", {stall, rdata, mem_req, mem_we, mem_addr, mem_wdata},
                           {1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0});
      check("rst_counters", {hit_cnt, miss_cnt}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_idle("post_rst");

      // Cold miss, hit after refill, store hit, store miss, conflict miss
      lat_cfg = 3;
      do_load(10'h010);
      check("cold_counts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
      do_load(10'h018);
      check("hit_count", hit_cnt, 16'd1);
      lat_cfg = 2;
      do_store(10'h014, 32'h0000DEAD, 1'b0);
      do_load(10'h014);
      do_store(10'h210, 32'h12345678, 1'b0);
      do_load(10'h010);
      lat_cfg = 3;
      do_load(10'h090);
      do_load(10'h010);

      // Reset during the second refill word
      @(negedge clk);
      mem_read = 1'b1; addr = 10'h050;
      rd_q.delete();
      for (int g = 0; g < 100 && rd_q.size() < 2; g++) begin
         @(negedge clk); #1;
      end
      check("mid_refill_req", mem_req, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_req", mem_req, 1'b0);
      check("rst_mid_cnt", {hit_cnt, miss_cnt}, 32'd0);
      mem_read = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_idle("rst_mid_after");
      do_load(10'h050);
      do_load(10'h054);

      // Randomised mix of loads and stores over a small tag range
      lat_cfg = 0;
      for (int n = 0; n < 300; n++) begin
         ra = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 2) == 0) do_store(ra, $urandom, 1'($urandom_range(0, 1)));
         else                           do_load(ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
